// File: rtl/sample_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sample_buffer_pkg
// Description : Shared layout constants and reader state encoding for the
//               multi-channel sample buffer. Both the capture writer and the
//               stream reader import this package so that the flat-buffer
//               layout (channel-major, oldest sample in the lowest byte) is
//               defined once.
// Revision    : 1.0 - initial release
// ============================================================================
package sample_buffer_pkg;

    localparam int         NUM_CHANNELS = 7;
    localparam int         SAMPLE_BITS  = 8;
    localparam int         DEPTH        = 10;
    localparam logic [7:0] HEADER_BYTE  = 8'hA5;
    localparam int         BUFFER_SIZE  = NUM_CHANNELS * DEPTH * SAMPLE_BITS;

    // Reader frame states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HEADER   = 2'd1,
        DATA     = 2'd2,
        CHECKSUM = 2'd3
    } reader_state_t;

    // Index width for a counter that must address n items (at least 1 bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_byte_mux.sv
`default_nettype none
// ============================================================================
// Module      : sample_byte_mux
// Description : Combinational selector returning sample [ch_idx, smp_idx]
//               from the flat snapshot of the sample buffer.
// Ports       : snapshot - flat buffer, channel c at [c*DEPTH*SB +: DEPTH*SB]
//               ch_idx   - channel select
//               smp_idx  - sample select within the channel (0 = oldest)
//               sample   - selected sample (0 if the index is out of range)
// Revision    : 1.0 - initial release
// ============================================================================
module sample_byte_mux #(
    parameter int NUM_CHANNELS = sample_buffer_pkg::NUM_CHANNELS,
    parameter int SAMPLE_BITS  = sample_buffer_pkg::SAMPLE_BITS,
    parameter int DEPTH        = sample_buffer_pkg::DEPTH,
    parameter int CH_W         = sample_buffer_pkg::idx_width(NUM_CHANNELS),
    parameter int SMP_W        = sample_buffer_pkg::idx_width(DEPTH)
) (
    input  logic [NUM_CHANNELS*DEPTH*SAMPLE_BITS-1:0] snapshot,
    input  logic [CH_W-1:0]                           ch_idx,
    input  logic [SMP_W-1:0]                          smp_idx,
    output logic [SAMPLE_BITS-1:0]                    sample
);
    import sample_buffer_pkg::*;

    localparam int TOTAL = NUM_CHANNELS * DEPTH;
    localparam int IDX_W = idx_width(TOTAL);

    logic [SAMPLE_BITS-1:0] w_bytes [TOTAL];
    logic [IDX_W-1:0]       w_index;

    generate
        for (genvar i = 0; i < TOTAL; i++) begin : g_unpack
            assign w_bytes[i] = snapshot[i*SAMPLE_BITS +: SAMPLE_BITS];
        end
    endgenerate

    // Channel-major linear index: channel c starts at c*DEPTH
    assign w_index = IDX_W'(ch_idx) * IDX_W'(DEPTH) + IDX_W'(smp_idx);

    always_comb begin
        sample = '0;
        // Past-the-end indices appear transiently when the reader's advance
        // logic wraps after the final sample; those are never consumed.
        if (int'(w_index) < TOTAL) begin
            sample = w_bytes[w_index];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sample_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : sample_stream_reader
// Description : Drain side of the multi-channel sample buffer. On start the
//               whole buffer is snapshotted and streamed as a framed byte
//               sequence over valid/ready: header byte, all samples
//               channel-major and oldest-first, then a mod-256 sum of the
//               sample bytes (flagged with out_last).
// Ports       : clk, reset    - clock, synchronous active-high reset
//               buf_data      - flat capture buffer
//               start         - frame request (pulse or level, ignored busy)
//               out_data      - current frame byte (registered)
//               out_valid     - out_data valid (registered)
//               out_ready     - sink accepts; transfer on valid & ready
//               out_last      - marks the checksum byte (registered)
//               busy          - frame in progress
//               done          - one-cycle pulse after the checksum transfer
//               frame_count   - completed frames, wraps at 256
// Revision    : 1.0 - initial release
// ============================================================================
module sample_stream_reader #(
    parameter int                                  NUM_CHANNELS = sample_buffer_pkg::NUM_CHANNELS,
    parameter int                                  SAMPLE_BITS  = sample_buffer_pkg::SAMPLE_BITS,
    parameter int                                  DEPTH        = sample_buffer_pkg::DEPTH,
    parameter logic [sample_buffer_pkg::SAMPLE_BITS-1:0] HEADER_BYTE = sample_buffer_pkg::HEADER_BYTE
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_CHANNELS*DEPTH*SAMPLE_BITS-1:0] buf_data,
    input  logic                                   start,
    output logic [SAMPLE_BITS-1:0]                 out_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   out_last,
    output logic                                   busy,
    output logic                                   done,
    output logic [7:0]                             frame_count
);
    import sample_buffer_pkg::*;

    localparam int CH_W  = idx_width(NUM_CHANNELS);
    localparam int SMP_W = idx_width(DEPTH);
    localparam int BUF_W = NUM_CHANNELS * DEPTH * SAMPLE_BITS;

    localparam logic [CH_W-1:0]  C_CH_LAST  = CH_W'(NUM_CHANNELS - 1);
    localparam logic [SMP_W-1:0] C_SMP_LAST = SMP_W'(DEPTH - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    reader_state_t          r_state;
    logic [CH_W-1:0]        r_ch_idx;
    logic [SMP_W-1:0]       r_smp_idx;
    logic [SAMPLE_BITS-1:0] r_checksum;
    logic [BUF_W-1:0]       r_snapshot;
    logic [SAMPLE_BITS-1:0] r_out_data;
    logic                   r_out_valid;
    logic                   r_out_last;
    logic                   r_done;
    logic [7:0]             r_frame_count;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    reader_state_t          w_state_nxt;
    logic [CH_W-1:0]        w_ch_nxt;
    logic [SMP_W-1:0]       w_smp_nxt;
    logic [SAMPLE_BITS-1:0] w_checksum_nxt;
    logic [SAMPLE_BITS-1:0] w_out_data_nxt;
    logic                   w_out_valid_nxt;
    logic                   w_out_last_nxt;
    logic                   w_done_nxt;
    logic [7:0]             w_frame_count_nxt;
    logic                   w_capture;

    logic                   w_handshake;
    logic                   w_smp_last;
    logic                   w_ch_last;
    logic [CH_W-1:0]        w_sel_ch;
    logic [SMP_W-1:0]       w_sel_smp;
    logic [SAMPLE_BITS-1:0] w_mux_byte;

    assign w_handshake = r_out_valid & out_ready;
    assign w_smp_last  = (r_smp_idx == C_SMP_LAST);
    assign w_ch_last   = (r_ch_idx == C_CH_LAST);

    // Index of the byte to present after the current handshake. Out_data is
    // registered, so the mux looks one position ahead: (0,0) while the header
    // is showing, otherwise the successor of the current DATA position.
    always_comb begin
        w_sel_ch  = '0;
        w_sel_smp = '0;
        if (r_state == DATA) begin
            if (w_smp_last) begin
                w_sel_smp = '0;
                w_sel_ch  = r_ch_idx + 1'b1;
            end else begin
                w_sel_smp = r_smp_idx + 1'b1;
                w_sel_ch  = r_ch_idx;
            end
        end
    end

    sample_byte_mux #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .SAMPLE_BITS  (SAMPLE_BITS),
        .DEPTH        (DEPTH),
        .CH_W         (CH_W),
        .SMP_W        (SMP_W)
    ) u_byte_mux (
        .snapshot (r_snapshot),
        .ch_idx   (w_sel_ch),
        .smp_idx  (w_sel_smp),
        .sample   (w_mux_byte)
    );

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_ch_nxt          = r_ch_idx;
        w_smp_nxt         = r_smp_idx;
        w_checksum_nxt    = r_checksum;
        w_out_data_nxt    = r_out_data;
        w_out_valid_nxt   = r_out_valid;
        w_out_last_nxt    = r_out_last;
        w_done_nxt        = 1'b0;
        w_frame_count_nxt = r_frame_count;
        w_capture         = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt     = HEADER;
                    w_capture       = 1'b1;
                    w_checksum_nxt  = '0;
                    w_ch_nxt        = '0;
                    w_smp_nxt       = '0;
                    w_out_data_nxt  = HEADER_BYTE;
                    w_out_valid_nxt = 1'b1;
                    w_out_last_nxt  = 1'b0;
                end
            end

            HEADER: begin
                if (w_handshake) begin
                    w_state_nxt    = DATA;
                    w_ch_nxt       = '0;
                    w_smp_nxt      = '0;
                    w_out_data_nxt = w_mux_byte;
                end
            end

            DATA: begin
                if (w_handshake) begin
                    // The byte currently held in out_data is being consumed
                    w_checksum_nxt = r_checksum + r_out_data;
                    if (w_ch_last && w_smp_last) begin
                        w_state_nxt    = CHECKSUM;
                        w_out_data_nxt = r_checksum + r_out_data;
                        w_out_last_nxt = 1'b1;
                    end else begin
                        w_ch_nxt       = w_sel_ch;
                        w_smp_nxt      = w_sel_smp;
                        w_out_data_nxt = w_mux_byte;
                    end
                end
            end

            CHECKSUM: begin
                if (w_handshake) begin
                    w_state_nxt       = IDLE;
                    w_ch_nxt          = '0;
                    w_smp_nxt         = '0;
                    w_out_data_nxt    = '0;
                    w_out_valid_nxt   = 1'b0;
                    w_out_last_nxt    = 1'b0;
                    w_done_nxt        = 1'b1;
                    w_frame_count_nxt = r_frame_count + 8'd1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_ch_idx      <= '0;
            r_smp_idx     <= '0;
            r_checksum    <= '0;
            r_snapshot    <= '0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_done        <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_ch_idx      <= w_ch_nxt;
            r_smp_idx     <= w_smp_nxt;
            r_checksum    <= w_checksum_nxt;
            r_out_data    <= w_out_data_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_out_last    <= w_out_last_nxt;
            r_done        <= w_done_nxt;
            r_frame_count <= w_frame_count_nxt;
            if (w_capture) begin
                r_snapshot <= buf_data;
            end
        end
    end

    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign out_last    = r_out_last;
    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_sample_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_stream_reader
// Description : Scoreboard bench for sample_stream_reader. Stimulus pushes
//               the expected frame (built from the buffer contents at start)
//               into a queue; a negedge monitor pops and compares on every
//               transfer and tracks done / frame_count / stall stability.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_stream_reader;
    import sample_buffer_pkg::*;

    localparam int FRAME_LEN = NUM_CHANNELS * DEPTH + 2;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   start = 1'b0;
    logic                   out_ready = 1'b1;
    logic [BUFFER_SIZE-1:0] buf_data = '0;
    logic [7:0]             out_data;
    logic                   out_valid;
    logic                   out_last;
    logic                   busy;
    logic                   done;
    logic [7:0]             frame_count;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         model_frames = 0;
    bit         rnd_ready = 1'b0;
    bit         done_pend = 1'b0;
    bit         held = 1'b0;
    logic [7:0] held_data;
    logic       held_last;
    exp_t       e;

    sample_stream_reader dut (
        .clk         (clk),
        .reset       (reset),
        .buf_data    (buf_data),
        .start       (start),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference frame: header, bytes in channel-major order, mod-256 sum
    task automatic push_frame(input logic [BUFFER_SIZE-1:0] b);
        int sum;
        logic [7:0] v;
        sum = 0;
        exp_q.push_back(exp_t'{data: HEADER_BYTE, last: 1'b0});
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            for (int s = 0; s < DEPTH; s++) begin
                v = b[(c*DEPTH + s)*8 +: 8];
                sum = sum + int'(v);
                exp_q.push_back(exp_t'{data: v, last: 1'b0});
            end
        end
        exp_q.push_back(exp_t'{data: 8'(sum % 256), last: 1'b1});
    endtask

    function automatic logic [BUFFER_SIZE-1:0] make_pattern();
        logic [BUFFER_SIZE-1:0] b;
        b = '0;
        for (int c = 0; c < NUM_CHANNELS; c++)
            for (int s = 0; s < DEPTH; s++)
                b[(c*DEPTH + s)*8 +: 8] = 8'(16*c + s);
        return b;
    endfunction

    task automatic wait_done(input int budget, output int cycles);
        bit fin;
        cycles = 0;
        fin = 1'b0;
        while (!fin) begin
            @(posedge clk); #1;
            cycles++;
            if (done) begin
                check("busy_at_done", 32'(busy), 32'd0);
                fin = 1'b1;
            end else if (cycles >= budget) begin
                total++;
                bad++;
                $display("FAIL done_timeout: got no done after %0d cycles expected done", cycles);
                fin = 1'b1;
            end
        end
    endtask

    // Sink readiness: always ready, or a random 50% pattern
    always @(posedge clk) begin
        #1;
        out_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            model_frames = 0;
            done_pend = 1'b0;
            held = 1'b0;
        end else begin
            check("done", 32'(done), 32'(done_pend));
            check("frame_count", 32'(frame_count), 32'(model_frames % 256));
            done_pend = 1'b0;
            if (held) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(held_data));
                check("stall_last", 32'(out_last), 32'(held_last));
            end
            held = out_valid && !out_ready;
            held_data = out_data;
            held_last = out_last;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got %0h expected no transfer", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", 32'(out_data), 32'(e.data));
                    check("last", 32'(out_last), 32'(e.last));
                    if (e.last) begin
                        model_frames = model_frames + 1;
                        done_pend = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BUFFER_SIZE-1:0] pat;
        logic [BUFFER_SIZE-1:0] b;
        int cyc;

        pat = make_pattern();

        // Reset
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(frame_count), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);

        // Frame 1: pattern, always ready, latency and bubble-free timing
        buf_data = pat;
        @(posedge clk); #1;
        push_frame(pat);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("hdr_valid", 32'(out_valid), 32'd1);
        check("hdr_data", 32'(out_data), 32'(HEADER_BYTE));
        check("hdr_busy", 32'(busy), 32'd1);
        wait_done(500, cyc);
        check("frame_cycles", 32'(cyc), 32'(FRAME_LEN));

        // Frame 2: random backpressure
        rnd_ready = 1'b1;
        push_frame(pat);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(5000, cyc);
        rnd_ready = 1'b0;

        // Frame 3: buffer overwritten two cycles after start
        @(posedge clk); #1;
        push_frame(pat);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        buf_data = '1;
        wait_done(500, cyc);
        buf_data = pat;

        // Frames 4-5: start held high, then pulses while busy
        @(posedge clk); #1;
        push_frame(pat);
        push_frame(pat);
        start = 1'b1;
        wait_done(500, cyc);
        check("gap_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("gap_hdr_valid", 32'(out_valid), 32'd1);
        check("gap_hdr_data", 32'(out_data), 32'(HEADER_BYTE));
        start = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 1) == 1);
        end
        start = 1'b0;
        wait_done(500, cyc);
        repeat (5) @(posedge clk);
        #1;
        check("no_extra_busy", 32'(busy), 32'd0);
        check("no_extra_q", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of DATA byte 30
        push_frame(pat);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (31) @(posedge clk);
        #1;
        check("byte30", 32'(out_data), 32'(pat[30*8 +: 8]));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_count", 32'(frame_count), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        push_frame(pat);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(500, cyc);

        // 256 back-to-back frames: zero, all-FF, then random buffers
        for (int i = 0; i < 256; i++) begin
            if (i == 0) begin
                b = '0;
            end else if (i == 1) begin
                b = '1;
            end else begin
                for (int k = 0; k < BUFFER_SIZE/8; k++)
                    b[k*8 +: 8] = 8'($urandom);
            end
            buf_data = b;
            push_frame(b);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            wait_done(500, cyc);
        end
        check("wrap_count", 32'(frame_count), 32'(model_frames % 256));

        repeat (3) @(posedge clk);
        #1;
        check("final_q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
